// File: rtl/dance_pkg.sv
// Shared types and constants for the LED-chaser front-end control stage.
package dance_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'b000,
        MODE_R2L    = 3'b001,
        MODE_L2R    = 3'b010,
        MODE_BOUNCE = 3'b100
    } mode_e;

    // Lowest-numbered switch wins when several are on.
    function automatic mode_e decode_mode(input logic [2:0] sw);
        if (sw[0]) begin
            return MODE_R2L;
        end else if (sw[1]) begin
            return MODE_L2R;
        end else if (sw[2]) begin
            return MODE_BOUNCE;
        end else begin
            return MODE_IDLE;
        end
    endfunction

endpackage

// File: rtl/dance_debounce.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw input.
module dance_debounce #(
    parameter int   DEB_CYCLES = 500000,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // A new level is taken only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            level_q <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/dance_ctrl.sv
// LED-chaser front end: debounced mode/speed inputs, step strobe generator
// and mode-change pulse for the downstream chaser.
module dance_ctrl
    import dance_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int BASE_DIV   = 131072,
    parameter int CNT_W      = 24
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [2:0]         SW,
    input  logic               KEY_up,
    input  logic               KEY_down,
    output logic [2:0]         mode,
    output logic               step,
    output logic               mode_change,
    output logic [SPEED_W-1:0] speed
);

    function automatic logic [SPEED_W-1:0] speed_sat(input logic [SPEED_W-1:0] spd,
                                                     input logic up, input logic dn);
        logic [SPEED_W-1:0] res;
        res = spd;
        if (up && !dn && (spd != SPEED_MAX)) begin
            res = spd + SPEED_W'(1);
        end else if (dn && !up && (spd != '0)) begin
            res = spd - SPEED_W'(1);
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] step_last(input logic [SPEED_W-1:0] spd);
        logic [31:0] period;
        period = 32'(BASE_DIV) << (SPEED_MAX - spd);
        return CNT_W'(period - 32'd1);
    endfunction

    logic [2:0] sw_acc;
    logic       key_up_acc;
    logic       key_dn_acc;

    for (genvar i = 0; i < 3; i++) begin : g_sw
        dance_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .RST_VAL   (1'b0)
        ) u_deb (
            .clk_i  (Clock),
            .rst_ni (Resetn),
            .raw_i  (SW[i]),
            .level_o(sw_acc[i])
        );
    end

    dance_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .RST_VAL   (1'b1)
    ) u_deb_up (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .raw_i  (KEY_up),
        .level_o(key_up_acc)
    );

    dance_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .RST_VAL   (1'b1)
    ) u_deb_dn (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .raw_i  (KEY_down),
        .level_o(key_dn_acc)
    );

    mode_e              mode_q, mode_d;
    logic               mode_change_q;
    logic               step_q, step_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               key_up_prev_q, key_dn_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               up_press, dn_press, restart;

    // Any mode or speed change restarts the period so the first step is a full period away.
    always_comb begin
        mode_d   = decode_mode(sw_acc);
        up_press = key_up_prev_q & ~key_up_acc;
        dn_press = key_dn_prev_q & ~key_dn_acc;
        speed_d  = speed_sat(speed_q, up_press, dn_press);
        restart  = (mode_d != mode_q) || (speed_d != speed_q);
        cnt_d    = '0;
        step_d   = 1'b0;
        if ((mode_d != MODE_IDLE) && !restart) begin
            if (cnt_q >= step_last(speed_d)) begin
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mode_q        <= MODE_IDLE;
            mode_change_q <= 1'b0;
            step_q        <= 1'b0;
            speed_q       <= '0;
            key_up_prev_q <= 1'b1;
            key_dn_prev_q <= 1'b1;
            cnt_q         <= '0;
        end else begin
            mode_q        <= mode_d;
            mode_change_q <= (mode_d != mode_q);
            step_q        <= step_d;
            speed_q       <= speed_d;
            key_up_prev_q <= key_up_acc;
            key_dn_prev_q <= key_dn_acc;
            cnt_q         <= cnt_d;
        end
    end

    assign mode        = mode_q;
    assign step        = step_q;
    assign mode_change = mode_change_q;
    assign speed       = speed_q;

endmodule
